// File: rtl/cp_load_align_pkg.sv
// Shared CP load/store definitions: LSU opcode encodings, load-return FSM
// state encodings, default watchdog limit and a misalignment helper.
// The helper is only referenced when CP_LSU_MISALIGN_TRAP_EN is defined.
package cp_load_align_pkg;

  // LSU opcode encodings driven by the AGU
  localparam int                              RISC24_CP_LSU_OP_WIDTH = 2;
  localparam logic [RISC24_CP_LSU_OP_WIDTH-1:0] RISC24_CP_LSU_OP_WORD  = 2'b00;
  localparam logic [RISC24_CP_LSU_OP_WIDTH-1:0] RISC24_CP_LSU_OP_HALF  = 2'b01;
  localparam logic [RISC24_CP_LSU_OP_WIDTH-1:0] RISC24_CP_LSU_OP_BYTE  = 2'b10;

  // Load-return FSM states
  localparam logic [1:0] CP_LSU_ST_IDLE   = 2'b00;
  localparam logic [1:0] CP_LSU_ST_ACCESS = 2'b01;
  localparam logic [1:0] CP_LSU_ST_WAIT   = 2'b10;

  // Default number of WAIT cycles tolerated before a load is abandoned
  localparam int CP_LSU_WAIT_TIMEOUT = 15;

  // A half-word needs an even address, a word needs a word-aligned address
  function automatic logic cpLsuIsMisaligned(
    input logic [RISC24_CP_LSU_OP_WIDTH-1:0] opcode,
    input logic [1:0]                        addrLow
  );
    return ((opcode == RISC24_CP_LSU_OP_HALF) && addrLow[0]) ||
           ((opcode == RISC24_CP_LSU_OP_WORD) && (addrLow != 2'b00));
  endfunction

endpackage

// File: rtl/cp_load_align_extract.sv
// cp_load_extract: purely combinational lane select and sign/zero extension
// of a raw 32-bit memory word. Shared with the PE load path, so it carries
// no state and no knowledge of the handshake. Only a 32-bit word is supported.
module cp_load_extract
  import cp_load_align_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [RISC24_CP_LSU_OP_WIDTH-1:0] iOpcode,
  input  logic [1:0]                        iAddrLow,
  input  logic                              iSigned,
  input  logic [DATA_WIDTH-1:0]             iData,
  output logic [DATA_WIDTH-1:0]             oData
);

  logic [7:0]  byteLane [4];
  logic [7:0]  selByte;
  logic [15:0] halfWord;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      assign byteLane[gi] = iData[8*gi +: 8];
    end
  endgenerate

  // Half-word lane chosen by A[1]; A[0] never moves the lane
  assign halfWord = iAddrLow[1] ? iData[31:16] : iData[15:0];
  assign selByte  = byteLane[iAddrLow];

  // Select the addressed field and extend it to the full word
  always_comb begin
    oData = '0;
    case (iOpcode)
      RISC24_CP_LSU_OP_WORD: oData = iData;
      RISC24_CP_LSU_OP_HALF: oData = {{16{iSigned & halfWord[15]}}, halfWord};
      RISC24_CP_LSU_OP_BYTE: oData = {{24{iSigned & selByte[7]}}, selByte};
      default:               oData = '0;
    endcase
  end

endmodule

// File: rtl/cp_load_align.sv
// cp_load_align: CP load-return stage. Latches load metadata at issue, waits
// for DMEM read data, aligns/extends it and emits a one-cycle register-file
// write. A watchdog aborts a load whose data never returns.
// Optional: define CP_LSU_MISALIGN_TRAP_EN to add oLSU_Misalign and suppress
// write-back of misaligned half-word/word loads.
module cp_load_align
  import cp_load_align_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WAIT_TIMEOUT   = CP_LSU_WAIT_TIMEOUT
) (
  input  logic                              iClk,
  input  logic                              iReset,
  input  logic                              iAGU_Read_Enable,
  input  logic [RISC24_CP_LSU_OP_WIDTH-1:0] iAGU_Opcode,
  input  logic [1:0]                        iAGU_Addr_Low,
  input  logic                              iID_Load_Signed,
  input  logic [REG_ADDR_WIDTH-1:0]         iID_Load_Dest,
  input  logic [DATA_WIDTH-1:0]             iDMEM_Read_Data,
  input  logic                              iDMEM_Data_Valid,
  output logic                              oLSU_Stall,
  output logic                              oLSU_WB_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0]         oLSU_WB_Dest,
  output logic [DATA_WIDTH-1:0]             oLSU_WB_Data,
  output logic                              oLSU_Pending_Valid,
  output logic [REG_ADDR_WIDTH-1:0]         oLSU_Pending_Dest,
`ifdef CP_LSU_MISALIGN_TRAP_EN
  output logic                              oLSU_Misalign,
`endif
  output logic                              oLSU_Timeout
);

  typedef struct packed {
    logic [RISC24_CP_LSU_OP_WIDTH-1:0] opcode;
    logic [1:0]                        addrLow;
    logic                              isSigned;
    logic [REG_ADDR_WIDTH-1:0]         dest;
  } loadMeta_t;

  localparam logic [7:0] TIMEOUT_COUNT = 8'(WAIT_TIMEOUT);

  logic [1:0] stateReg, stateNext;
  logic [7:0] waitCountReg, waitCountNext;
  loadMeta_t  metaReg, metaNext;
  loadMeta_t  issueMeta;

  logic busy;
  logic dataReturn;
  logic timeoutHit;
  logic misalignHit;
  logic writeBack;
  logic [DATA_WIDTH-1:0] extractData;

  assign issueMeta = '{opcode:   iAGU_Opcode,
                       addrLow:  iAGU_Addr_Low,
                       isSigned: iID_Load_Signed,
                       dest:     iID_Load_Dest};

  assign busy       = (stateReg != CP_LSU_ST_IDLE);
  assign dataReturn = busy && iDMEM_Data_Valid;
  assign timeoutHit = (stateReg == CP_LSU_ST_WAIT) && !iDMEM_Data_Valid &&
                      (waitCountReg == TIMEOUT_COUNT);

`ifdef CP_LSU_MISALIGN_TRAP_EN
  assign misalignHit   = dataReturn && cpLsuIsMisaligned(metaReg.opcode, metaReg.addrLow);
  assign oLSU_Misalign = misalignHit && !iReset;
`else
  assign misalignHit = 1'b0;
`endif

  // The handshake still completes on a misaligned load; only the write is dropped
  assign writeBack = dataReturn && !misalignHit && !iReset;

  cp_load_extract #(
    .DATA_WIDTH (DATA_WIDTH)
  ) uExtract (
    .iOpcode  (metaReg.opcode),
    .iAddrLow (metaReg.addrLow),
    .iSigned  (metaReg.isSigned),
    .iData    (iDMEM_Read_Data),
    .oData    (extractData)
  );

  // Outputs are forced low while reset is asserted so a dropped load never writes
  always_comb begin
    oLSU_Stall           = busy && !iDMEM_Data_Valid && !iReset;
    oLSU_WB_Write_Enable = writeBack;
    oLSU_WB_Dest         = writeBack ? metaReg.dest : '0;
    oLSU_WB_Data         = writeBack ? extractData : '0;
    oLSU_Pending_Valid   = busy && !iReset;
    oLSU_Pending_Dest    = (busy && !iReset) ? metaReg.dest : '0;
    oLSU_Timeout         = timeoutHit && !iReset;
  end

  // Next-state logic; a new load is only taken when the stall is low, which
  // includes the cycle data returns, so back-to-back loads run one per cycle
  always_comb begin
    stateNext     = stateReg;
    waitCountNext = waitCountReg;
    metaNext      = metaReg;
    case (stateReg)
      CP_LSU_ST_IDLE: begin
        if (iAGU_Read_Enable) begin
          metaNext  = issueMeta;
          stateNext = CP_LSU_ST_ACCESS;
        end
      end
      CP_LSU_ST_ACCESS: begin
        if (iDMEM_Data_Valid) begin
          if (iAGU_Read_Enable) begin
            metaNext  = issueMeta;
            stateNext = CP_LSU_ST_ACCESS;
          end else begin
            stateNext = CP_LSU_ST_IDLE;
          end
        end else begin
          stateNext     = CP_LSU_ST_WAIT;
          waitCountNext = 8'd1;
        end
      end
      CP_LSU_ST_WAIT: begin
        if (iDMEM_Data_Valid) begin
          waitCountNext = 8'd0;
          // Stall is low this cycle, so the AGU considers a request accepted
          if (iAGU_Read_Enable) begin
            metaNext  = issueMeta;
            stateNext = CP_LSU_ST_ACCESS;
          end else begin
            stateNext = CP_LSU_ST_IDLE;
          end
        end else if (waitCountReg == TIMEOUT_COUNT) begin
          waitCountNext = 8'd0;
          stateNext     = CP_LSU_ST_IDLE;
        end else begin
          waitCountNext = waitCountReg + 8'd1;
        end
      end
      default: begin
        stateNext     = CP_LSU_ST_IDLE;
        waitCountNext = 8'd0;
      end
    endcase
  end

  // State, watchdog and metadata registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iReset) begin
      stateReg     <= CP_LSU_ST_IDLE;
      waitCountReg <= 8'd0;
      metaReg      <= '0;
    end else begin
      stateReg     <= stateNext;
      waitCountReg <= waitCountNext;
      metaReg      <= metaNext;
    end
  end

endmodule

// File: tb/tb_cp_load_align.sv
// Testbench for cp_load_align: scenario tasks with a scoreboard queue of
// expected write-backs, filled at issue and drained in the data-valid cycle.
module tb_cp_load_align;
  import cp_load_align_pkg::*;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        readEn;
  logic [1:0]  opcode;
  logic [1:0]  addrLow;
  logic        loadSigned;
  logic [4:0]  loadDest;
  logic [31:0] rdData;
  logic        rdValid;
  logic        stall;
  logic        wbEn;
  logic [4:0]  wbDest;
  logic [31:0] wbData;
  logic        pendValid;
  logic [4:0]  pendDest;
  logic        timeoutPulse;
`ifdef CP_LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  exp_t sbQueue[$];
  int   checkCount = 0;
  int   passCount  = 0;

  cp_load_align #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .WAIT_TIMEOUT   (15)
  ) dut (
    .iClk                 (clk),
    .iReset               (rst),
    .iAGU_Read_Enable     (readEn),
    .iAGU_Opcode          (opcode),
    .iAGU_Addr_Low        (addrLow),
    .iID_Load_Signed      (loadSigned),
    .iID_Load_Dest        (loadDest),
    .iDMEM_Read_Data      (rdData),
    .iDMEM_Data_Valid     (rdValid),
    .oLSU_Stall           (stall),
    .oLSU_WB_Write_Enable (wbEn),
    .oLSU_WB_Dest         (wbDest),
    .oLSU_WB_Data         (wbData),
    .oLSU_Pending_Valid   (pendValid),
    .oLSU_Pending_Dest    (pendDest),
`ifdef CP_LSU_MISALIGN_TRAP_EN
    .oLSU_Misalign        (misalign),
`endif
    .oLSU_Timeout         (timeoutPulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alignment written with shifts rather than lane muxes
  function automatic logic [31:0] modelLoad(input logic [1:0] op, input logic [1:0] a,
                                            input logic sgn, input logic [31:0] d);
    logic [31:0] sh;
    if (op == RISC24_CP_LSU_OP_WORD) return d;
    if (op == RISC24_CP_LSU_OP_HALF) begin
      sh = d >> (a[1] ? 16 : 0);
      return sgn ? 32'($signed(sh[15:0])) : {16'h0000, sh[15:0]};
    end
    if (op == RISC24_CP_LSU_OP_BYTE) begin
      sh = d >> (8 * a);
      return sgn ? 32'($signed(sh[7:0])) : {24'h000000, sh[7:0]};
    end
    return 32'h0;
  endfunction

  task automatic driveIdle();
    readEn = 1'b0; opcode = 2'b00; addrLow = 2'b00; loadSigned = 1'b0;
    loadDest = 5'd0; rdData = 32'h0; rdValid = 1'b0;
  endtask

  task automatic driveIssue(input logic [1:0] op, input logic [1:0] a,
                            input logic sgn, input logic [4:0] dst);
    readEn = 1'b1; opcode = op; addrLow = a; loadSigned = sgn; loadDest = dst;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    driveIdle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({stall, wbEn, wbDest, wbData, pendValid, pendDest, timeoutPulse} !== '0)
      $display("FAIL reset_held: outputs=%h required 0",
               {stall, wbEn, wbDest, wbData, pendValid, pendDest, timeoutPulse});
    else passCount++;
    nextCycle();
    rst = 1'b0;
    rdValid = 1'b1; rdData = 32'hFFFF_FFFF;  // valid in IDLE must be ignored
    @(negedge clk);
    checkCount++;
    if ({stall, wbEn, wbData, pendValid, timeoutPulse} !== '0)
      $display("FAIL reset_idle: outputs=%h required 0",
               {stall, wbEn, wbData, pendValid, timeoutPulse});
    else passCount++;
    nextCycle();
    driveIdle();
  endtask

  task automatic test_signed_byte();
    exp_t e;
    int   stallSeen = 0;
    driveIssue(RISC24_CP_LSU_OP_BYTE, 2'b11, 1'b1, 5'd5);
    sbQueue.push_back('{dest: 5'd5, data: modelLoad(RISC24_CP_LSU_OP_BYTE, 2'b11, 1'b1, 32'h8000_0000)});
    @(negedge clk);
    stallSeen += int'(stall);
    nextCycle();
    driveIdle();
    rdValid = 1'b1; rdData = 32'h8000_0000;
    @(negedge clk);
    stallSeen += int'(stall);
    checkCount++;
    if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
      $display("FAIL sbyte_wb_en: got %b required 1", wbEn);
    end else begin
      e = sbQueue.pop_front();
      if (wbData !== e.data || wbDest !== e.dest)
        $display("FAIL sbyte_wb: data=%h dest=%0d required data=%h dest=%0d", wbData, wbDest, e.data, e.dest);
      else passCount++;
    end
    nextCycle();
    driveIdle();
    @(negedge clk);
    stallSeen += int'(stall);
    checkCount++;
    if (wbEn !== 1'b0 || wbData !== 32'h0)
      $display("FAIL sbyte_strobe_len: wbEn=%b data=%h required 0/0", wbEn, wbData);
    else passCount++;
    checkCount++;
    if (stallSeen != 0) $display("FAIL sbyte_stall: stall cycles=%0d required 0", stallSeen);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_wait_half();
    exp_t e;
    int   stallCycles = 0;
    int   pendOk = 1;
    driveIssue(RISC24_CP_LSU_OP_HALF, 2'b10, 1'b0, 5'd9);
    sbQueue.push_back('{dest: 5'd9, data: modelLoad(RISC24_CP_LSU_OP_HALF, 2'b10, 1'b0, 32'hBEEF_1234)});
    nextCycle();
    driveIdle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stallCycles += int'(stall);
      if (pendValid !== 1'b1 || pendDest !== 5'd9 || wbEn !== 1'b0) pendOk = 0;
      nextCycle();
    end
    rdValid = 1'b1; rdData = 32'hBEEF_1234;
    @(negedge clk);
    checkCount++;
    if (stallCycles != 3 || stall !== 1'b0)
      $display("FAIL half_stall: stall cycles=%0d final=%b required 3/0", stallCycles, stall);
    else passCount++;
    checkCount++;
    if (pendOk != 1) $display("FAIL half_pending: pending outputs wrong while waiting, required valid=1 dest=9");
    else passCount++;
    checkCount++;
    if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
      $display("FAIL half_wb_en: got %b required 1", wbEn);
    end else begin
      e = sbQueue.pop_front();
      if (wbData !== e.data || wbDest !== e.dest)
        $display("FAIL half_wb: data=%h dest=%0d required data=%h dest=%0d", wbData, wbDest, e.data, e.dest);
      else passCount++;
    end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkCount++;
    if (pendValid !== 1'b0 || pendDest !== 5'd0)
      $display("FAIL half_idle: pending=%b dest=%0d required 0/0", pendValid, pendDest);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   stallSeen = 0;
    for (int i = 0; i < 5; i++) begin
      driveIdle();
      if (i < 4) begin
        driveIssue(RISC24_CP_LSU_OP_WORD, 2'b00, 1'b0, 5'(10 + i));
        sbQueue.push_back('{dest: 5'(10 + i), data: 32'hA5A5_0000 + 32'(i)});
      end
      if (i > 0) begin
        rdValid = 1'b1;
        rdData  = 32'hA5A5_0000 + 32'(i - 1);
      end
      @(negedge clk);
      stallSeen += int'(stall);
      if (i > 0) begin
        checkCount++;
        if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
          $display("FAIL b2b_wb_en[%0d]: got %b required 1", i, wbEn);
        end else begin
          e = sbQueue.pop_front();
          if (wbData !== e.data || wbDest !== e.dest)
            $display("FAIL b2b_wb[%0d]: data=%h dest=%0d required data=%h dest=%0d", i, wbData, wbDest, e.data, e.dest);
          else passCount++;
        end
      end
      nextCycle();
    end
    driveIdle();
    checkCount++;
    if (stallSeen != 0) $display("FAIL b2b_stall: stall cycles=%0d required 0", stallSeen);
    else passCount++;
  endtask

  // Table of immediate-return loads covering lanes, signs and the illegal opcode
  task automatic test_align();
    exp_t        e;
    logic [1:0]  ops  [7] = '{RISC24_CP_LSU_OP_HALF, RISC24_CP_LSU_OP_HALF, RISC24_CP_LSU_OP_BYTE,
                             RISC24_CP_LSU_OP_BYTE, RISC24_CP_LSU_OP_BYTE, RISC24_CP_LSU_OP_HALF, 2'b11};
    logic [1:0]  addrs[7] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00};
    logic        sgns [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] words[7] = '{32'h0000_8001, 32'h7FFF_FFFF, 32'h1234_F678, 32'h00C3_0000,
                             32'h0000_007F, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      driveIssue(ops[i], addrs[i], sgns[i], 5'(20 + i));
      sbQueue.push_back('{dest: 5'(20 + i), data: modelLoad(ops[i], addrs[i], sgns[i], words[i])});
      nextCycle();
      driveIdle();
      rdValid = 1'b1; rdData = words[i];
      @(negedge clk);
      checkCount++;
      if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
        $display("FAIL align_wb_en[%0d]: got %b required 1", i, wbEn);
      end else begin
        e = sbQueue.pop_front();
        if (wbData !== e.data || wbDest !== e.dest)
          $display("FAIL align[%0d]: data=%h dest=%0d required data=%h dest=%0d", i, wbData, wbDest, e.data, e.dest);
        else passCount++;
      end
      nextCycle();
      driveIdle();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   pulseAt = -1;
    int   pulses  = 0;
    int   wbSeen  = 0;
    driveIssue(RISC24_CP_LSU_OP_WORD, 2'b00, 1'b0, 5'd7);
    nextCycle();
    driveIdle();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeoutPulse === 1'b1) begin
        pulses++;
        if (pulseAt < 0) pulseAt = k;
      end
      wbSeen += int'(wbEn);
      nextCycle();
    end
    checkCount++;
    if (pulseAt != 16 || pulses != 1)
      $display("FAIL timeout_pulse: at cycle %0d count %0d required cycle 16 count 1", pulseAt, pulses);
    else passCount++;
    checkCount++;
    if (wbSeen != 0 || pendValid !== 1'b0)
      $display("FAIL timeout_nowb: wb strobes=%0d pending=%b required 0/0", wbSeen, pendValid);
    else passCount++;
    driveIssue(RISC24_CP_LSU_OP_WORD, 2'b00, 1'b0, 5'd8);
    sbQueue.push_back('{dest: 5'd8, data: 32'hCAFE_F00D});
    nextCycle();
    driveIdle();
    rdValid = 1'b1; rdData = 32'hCAFE_F00D;
    @(negedge clk);
    checkCount++;
    if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
      $display("FAIL timeout_next_wb_en: got %b required 1", wbEn);
    end else begin
      e = sbQueue.pop_front();
      if (wbData !== e.data || wbDest !== e.dest)
        $display("FAIL timeout_next: data=%h dest=%0d required data=%h dest=%0d", wbData, wbDest, e.data, e.dest);
      else passCount++;
    end
    nextCycle();
    driveIdle();
  endtask

  task automatic test_reset_midload();
    // Issue, ACCESS, first WAIT, then reset during the second WAIT cycle
    driveIssue(RISC24_CP_LSU_OP_WORD, 2'b00, 1'b0, 5'd3);
    nextCycle();
    driveIdle();
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    rdValid = 1'b1; rdData = 32'h5555_AAAA;
    @(negedge clk);
    checkCount++;
    if ({stall, wbEn, wbDest, wbData, pendValid, pendDest, timeoutPulse} !== '0)
      $display("FAIL midreset: outputs=%h required 0",
               {stall, wbEn, wbDest, wbData, pendValid, pendDest, timeoutPulse});
    else passCount++;
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkCount++;
    if (wbEn !== 1'b0 || pendValid !== 1'b0)
      $display("FAIL midreset_after: wbEn=%b pending=%b required 0/0", wbEn, pendValid);
    else passCount++;
    nextCycle();
  endtask

  task automatic test_misalign();
    exp_t e;
    driveIssue(RISC24_CP_LSU_OP_WORD, 2'b01, 1'b0, 5'd12);
`ifndef CP_LSU_MISALIGN_TRAP_EN
    sbQueue.push_back('{dest: 5'd12, data: 32'h1234_5678});
`endif
    nextCycle();
    driveIdle();
    rdValid = 1'b1; rdData = 32'h1234_5678;
    @(negedge clk);
`ifdef CP_LSU_MISALIGN_TRAP_EN
    checkCount++;
    if (misalign !== 1'b1 || wbEn !== 1'b0 || wbData !== 32'h0 || stall !== 1'b0)
      $display("FAIL misalign_trap: misalign=%b wbEn=%b data=%h stall=%b required 1/0/0/0",
               misalign, wbEn, wbData, stall);
    else passCount++;
`else
    checkCount++;
    if (wbEn !== 1'b1 || sbQueue.size() == 0) begin
      $display("FAIL misalign_wb_en: got %b required 1", wbEn);
    end else begin
      e = sbQueue.pop_front();
      if (wbData !== e.data || wbDest !== e.dest)
        $display("FAIL misalign_word: data=%h dest=%0d required data=%h dest=%0d", wbData, wbDest, e.data, e.dest);
      else passCount++;
    end
`endif
    nextCycle();
    driveIdle();
    @(negedge clk);
    checkCount++;
    if (pendValid !== 1'b0) $display("FAIL misalign_idle: pending=%b required 0", pendValid);
    else passCount++;
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_signed_byte();
    test_wait_half();
    test_back_to_back();
    test_align();
    test_timeout();
    test_reset_midload();
    test_misalign();
    checkCount++;
    if (sbQueue.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", sbQueue.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard bound on simulated time so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
